// File: rtl/game_of_life_grid.sv
// Conway Life (B3/S23) engine on a WIDTH x HEIGHT field, one generation per clock, with run/step/load control.
// Define GOL_PERIOD2_DETECT_EN to add period-2 oscillator detection (history register, osc2 output).
module game_of_life_grid #(
  parameter int WIDTH          = 5,
  parameter int HEIGHT         = 5,
  parameter int WRAP           = 0,
  parameter int GEN_W          = 16,
  parameter int STOP_ON_STABLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [WIDTH*HEIGHT-1:0]   field_in,
  input  logic                      run,
  input  logic                      step,
  output logic [WIDTH*HEIGHT-1:0]   field,
  output logic [GEN_W-1:0]          generation,
  output logic                      running,
  output logic                      stable,
  output logic                      extinct,
  output logic                      osc2
);

  localparam int N = WIDTH * HEIGHT;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t         state;
  logic [N-1:0]   nxt;
  logic           is_still;
  logic           hit_osc;
  logic           do_upd;

  function automatic logic life_rule(input logic cur, input logic [8:0] nb);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 9; i++) cnt = cnt + {3'b000, nb[i]};
    return (cnt == 4'd3) || (cur && (cnt == 4'd2));
  endfunction

  function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] g);
    return (&g) ? g : g + 1'b1;
  endfunction

  // Neighbourhood taps are resolved at elaboration: wrapped or dead border per cell.
  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      logic [8:0] nb;
      for (genvar dr = 0; dr < 3; dr++) begin : g_dr
        for (genvar dc = 0; dc < 3; dc++) begin : g_dc
          localparam int  RR  = r + dr - 1;
          localparam int  CC  = c + dc - 1;
          localparam int  RW  = (RR + HEIGHT) % HEIGHT;
          localparam int  CW  = (CC + WIDTH) % WIDTH;
          localparam bit  INB = (RR >= 0) && (RR < HEIGHT) && (CC >= 0) && (CC < WIDTH);
          if (dr == 1 && dc == 1) begin : g_ctr
            assign nb[dr*3+dc] = 1'b0;
          end else if (WRAP != 0 || INB) begin : g_tap
            assign nb[dr*3+dc] = field[RW*WIDTH+CW];
          end else begin : g_dead
            assign nb[dr*3+dc] = 1'b0;
          end
        end
      end
      assign nxt[r*WIDTH+c] = life_rule(field[r*WIDTH+c], nb);
    end
  end

  assign is_still = (nxt == field);
  assign extinct  = ~|field;
  assign do_upd   = !load && (((state == IDLE) && !run && step) || ((state == RUN) && run));

`ifdef GOL_PERIOD2_DETECT_EN
  logic [N-1:0] hist;
  logic         hist_vld;

  // hist_vld keeps a cleared history from matching a pattern that dies out.
  assign hit_osc = hist_vld && (nxt == hist) && !is_still;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     <= '0;
      hist_vld <= 1'b0;
      osc2     <= 1'b0;
    end else if (load) begin
      hist     <= '0;
      hist_vld <= 1'b0;
      osc2     <= 1'b0;
    end else if (do_upd && !is_still) begin
      hist     <= field;
      hist_vld <= 1'b1;
      if (hit_osc) osc2 <= 1'b1;
    end
  end
`else
  assign hit_osc = 1'b0;
  assign osc2    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      field      <= '0;
      generation <= '0;
      stable     <= 1'b0;
      running    <= 1'b0;
      state      <= IDLE;
    end else if (load) begin
      field      <= field_in;
      generation <= '0;
      stable     <= 1'b0;
      running    <= 1'b0;
      state      <= IDLE;
    end else begin
      if (do_upd) begin
        if (is_still) begin
          stable <= 1'b1;
        end else begin
          field      <= nxt;
          generation <= sat_inc(generation);
        end
      end
      case (state)
        IDLE: begin
          if (run) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (!run) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if ((STOP_ON_STABLE != 0) && (is_still || hit_osc)) begin
            state   <= HALT;
            running <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_of_life_grid.sv
// Directed bench for game_of_life_grid: three instances (dead border, torus, torus with 4-bit counter) share stimulus.
module tb_game_of_life_grid;

  logic        clk = 1'b0;
  logic        rst, load, run, step;
  logic [24:0] field_in;

  logic [24:0] a_field, b_field, c_field;
  logic [15:0] a_gen, b_gen;
  logic [3:0]  c_gen;
  logic        a_running, a_stable, a_extinct, a_osc2;
  logic        b_running, b_stable, b_extinct, b_osc2;
  logic        c_running, c_stable, c_extinct, c_osc2;

  int total = 0;
  int bad   = 0;

  localparam logic [24:0] VBLINK = 25'h0021080;
  localparam logic [24:0] HBLINK = 25'h0003800;
  localparam logic [24:0] BLOCK  = 25'h00018C0;
  localparam logic [24:0] GLIDER = 25'h0001C82;

  game_of_life_grid #(.WIDTH(5), .HEIGHT(5), .WRAP(0), .GEN_W(16), .STOP_ON_STABLE(1)) u_a (
    .clk(clk), .rst(rst), .load(load), .field_in(field_in), .run(run), .step(step),
    .field(a_field), .generation(a_gen), .running(a_running), .stable(a_stable),
    .extinct(a_extinct), .osc2(a_osc2));

  game_of_life_grid #(.WIDTH(5), .HEIGHT(5), .WRAP(1), .GEN_W(16), .STOP_ON_STABLE(1)) u_b (
    .clk(clk), .rst(rst), .load(load), .field_in(field_in), .run(run), .step(step),
    .field(b_field), .generation(b_gen), .running(b_running), .stable(b_stable),
    .extinct(b_extinct), .osc2(b_osc2));

  game_of_life_grid #(.WIDTH(5), .HEIGHT(5), .WRAP(1), .GEN_W(4), .STOP_ON_STABLE(1)) u_c (
    .clk(clk), .rst(rst), .load(load), .field_in(field_in), .run(run), .step(step),
    .field(c_field), .generation(c_gen), .running(c_running), .stable(c_stable),
    .extinct(c_extinct), .osc2(c_osc2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [24:0] p);
    load     = 1'b1;
    field_in = p;
    tick();
    load     = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; field_in = '0;
    #3;
    chk("rst_field",   {7'd0, a_field}, 32'd0);
    chk("rst_gen",     {16'd0, a_gen}, 32'd0);
    chk("rst_running", {31'd0, a_running}, 32'd0);
    chk("rst_stable",  {31'd0, a_stable}, 32'd0);
    chk("rst_extinct", {31'd0, a_extinct}, 32'd1);
    chk("rst_osc2",    {31'd0, a_osc2}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Empty field is a still life on first compute.
    pulse_step();
    chk("empty_stable", {31'd0, a_stable}, 32'd1);
    chk("empty_gen",    {16'd0, a_gen}, 32'd0);

    // Blinker stepped twice from IDLE.
    do_load(VBLINK);
    chk("ld_stable",  {31'd0, a_stable}, 32'd0);
    chk("ld_extinct", {31'd0, a_extinct}, 32'd0);
    pulse_step();
    chk("t1_field1", {7'd0, a_field}, {7'd0, HBLINK});
    chk("t1_gen1",   {16'd0, a_gen}, 32'd1);
    pulse_step();
    chk("t1_field2", {7'd0, a_field}, {7'd0, VBLINK});
    chk("t1_gen2",   {16'd0, a_gen}, 32'd2);
    chk("t1_idle",   {31'd0, a_running}, 32'd0);

    // Corner blinker: dead border vs torus.
    do_load(25'h0000007);
    pulse_step();
    chk("t3_nowrap", {7'd0, a_field}, 32'h0000042);
    chk("t3_wrap",   {7'd0, b_field}, 32'h0200042);
    chk("t3_wrap4",  {7'd0, c_field}, 32'h0200042);

    // Block halts on its first RUN update.
    do_load(BLOCK);
    run = 1'b1;
    tick();
    chk("t2_run",     {31'd0, a_running}, 32'd1);
    chk("t2_gen0",    {16'd0, a_gen}, 32'd0);
    tick();
    chk("t2_field",   {7'd0, a_field}, {7'd0, BLOCK});
    chk("t2_gen",     {16'd0, a_gen}, 32'd0);
    chk("t2_stable",  {31'd0, a_stable}, 32'd1);
    chk("t2_halted",  {31'd0, a_running}, 32'd0);
    step = 1'b1;
    tick(3);
    step = 1'b0;
    chk("t2_frozen",  {7'd0, a_field}, {7'd0, BLOCK});
    chk("t2_stay",    {31'd0, a_running}, 32'd0);
    run = 1'b0;
    tick();

    // Blinker under RUN: period-2 detection if compiled in.
    do_load(VBLINK);
    run = 1'b1;
    tick();
    tick();
    chk("t6_g1", {7'd0, a_field}, {7'd0, HBLINK});
    tick();
    chk("t6_g2",     {7'd0, a_field}, {7'd0, VBLINK});
    chk("t6_gen2",   {16'd0, a_gen}, 32'd2);
`ifdef GOL_PERIOD2_DETECT_EN
    chk("t6_osc2",   {31'd0, a_osc2}, 32'd1);
    chk("t6_halt",   {31'd0, a_running}, 32'd0);
    tick();
    chk("t6_frozen", {7'd0, a_field}, {7'd0, VBLINK});
    chk("t6_gfrz",   {16'd0, a_gen}, 32'd2);
`else
    chk("t6_osc2",   {31'd0, a_osc2}, 32'd0);
    chk("t6_run",    {31'd0, a_running}, 32'd1);
    tick();
    chk("t6_g3",     {7'd0, a_field}, {7'd0, HBLINK});
    chk("t6_gen3",   {16'd0, a_gen}, 32'd3);
`endif
    run = 1'b0;
    tick();
    chk("t6_stop", {31'd0, a_running}, 32'd0);

    // Asynchronous reset in the middle of a run.
    do_load(GLIDER);
    run = 1'b1;
    tick(3);
    chk("rr_running", {31'd0, a_running}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rr_field",   {7'd0, a_field}, 32'd0);
    chk("rr_gen",     {16'd0, a_gen}, 32'd0);
    chk("rr_running", {31'd0, a_running}, 32'd0);
    chk("rr_extinct", {31'd0, a_extinct}, 32'd1);
    chk("rr_stable",  {31'd0, a_stable}, 32'd0);
    run = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Glider on the torus returns home after 20 generations.
    do_load(GLIDER);
    run = 1'b1;
    tick();
    for (int i = 0; i < 100 && b_gen != 16'd20; i++) tick();
    run = 1'b0;
    tick();
    chk("t4_gen",     {16'd0, b_gen}, 32'd20);
    chk("t4_field",   {7'd0, b_field}, {7'd0, GLIDER});
    chk("t4_idle",    {31'd0, b_running}, 32'd0);
    chk("t5_sat20",   {28'd0, c_gen}, 32'd15);

    // Saturated counter, then load with run held high.
    run = 1'b1;
    tick(6);
    chk("t5_sat25",   {28'd0, c_gen}, 32'd15);
    chk("t5_running", {31'd0, c_running}, 32'd1);
    load = 1'b1;
    field_in = GLIDER;
    tick();
    load = 1'b0;
    chk("t5_ld_gen",  {28'd0, c_gen}, 32'd0);
    chk("t5_ld_idle", {31'd0, c_running}, 32'd0);
    chk("t5_ld_fld",  {7'd0, c_field}, {7'd0, GLIDER});
    tick();
    chk("t5_rerun",   {31'd0, c_running}, 32'd1);
    chk("t5_gen0",    {28'd0, c_gen}, 32'd0);
    tick();
    chk("t5_gen1",    {28'd0, c_gen}, 32'd1);
    run = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
